fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of `instructionMemory`. It owns the program counter, drives the 8-bit word index into the memory, and captures the returned 32-bit word into an IF/ID output register with a valid/ready handshake toward decode. It also handles:
- branch/jump redirects from execute;
- detection of the halt word `32'hFFFFFFFF`;
- a sticky fault on illegal redirect targets.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 24 ++
 rtl/if_id_reg.sv | 38 +++
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, special instruction words,
// and the redirect-target legality check.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_FAULT  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

   // A target is legal when it is word aligned and lies inside the addressable word range.
   function automatic logic redirect_legal(input logic [31:0] addr, input int unsigned addr_w);
      return (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == 32'd0);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, IF/ID valid/ready output and execute redirect.
// The master modport is the fetch side; the slave modport is memory/decode/execute.
interface fetch_unit_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] imem_pc;
   logic [31:0]       imem_instr;
   logic              out_valid;
   logic [ADDR_W-1:0] out_pc;
   logic [31:0]       out_instr;
   logic              id_ready;
   logic              redirect_valid;
   logic [31:0]       redirect_addr;

   modport master (
      output imem_pc, out_valid, out_pc, out_instr,
      input  imem_instr, id_ready, redirect_valid, redirect_addr
   );

   modport slave (
      input  imem_pc, out_valid, out_pc, out_instr,
      output imem_instr, id_ready, redirect_valid, redirect_addr
   );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID output register, one-cycle latency; holds its entry while valid && !ready.
// Kill beats load, load beats drain; an empty register always shows NOP_WORD.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_kill,
   input  logic              i_ready,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [31:0]       i_instr,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_pc,
   output logic [31:0]       o_instr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         o_pc    <= '0;
         o_instr <= NOP_WORD;
      end else if (i_kill) begin
         o_valid <= 1'b0;
         o_instr <= NOP_WORD;
      end else if (i_load) begin
         o_valid <= 1'b1;
         o_pc    <= i_pc;
         o_instr <= i_instr;
      end else if (o_valid && i_ready) begin
         o_valid <= 1'b0;
         o_instr <= NOP_WORD;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one-cycle fetch into the IF/ID register, stalls on !id_ready.
// Redirects kill the IF/ID entry; the halt word parks fetch; illegal targets fault until reset.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus,
   output logic         halted,
   output logic         fault,
   output logic [31:0]  fetch_count
);

   localparam logic [1:0] S_RUN    = ST_RUN;
   localparam logic [1:0] S_HALTED = ST_HALTED;
   localparam logic [1:0] S_FAULT  = ST_FAULT;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [31:0]       r_count;

   logic w_redirect;
   logic w_legal;
   logic w_is_halt;
   logic w_can_load;
   logic w_kill;
   logic w_xfer;

   assign w_redirect = bus.redirect_valid && (r_state != S_FAULT);
   assign w_legal    = redirect_legal(bus.redirect_addr, ADDR_W);
   assign w_is_halt  = (bus.imem_instr == HALT_WORD);
   assign w_can_load = (r_state == S_RUN) && !bus.redirect_valid
                       && (!bus.out_valid || bus.id_ready);
   assign w_kill     = w_redirect || (r_state == S_FAULT);
   // A transfer coinciding with a redirect is wrong-path and is not counted.
   assign w_xfer     = bus.out_valid && bus.id_ready && !bus.redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_pc    <= RESET_PC;
         r_count <= '0;
      end else begin
         if (w_redirect) begin
            if (w_legal) begin
               r_pc    <= bus.redirect_addr[ADDR_W+1:2];
               r_state <= S_RUN;
            end else begin
               r_state <= S_FAULT;
            end
         end else if (w_can_load) begin
            if (w_is_halt) r_state <= S_HALTED;
            else           r_pc    <= r_pc + 1'b1;
         end
         if (w_xfer) r_count <= r_count + 32'd1;
      end
   end

   if_id_reg #(
      .ADDR_W (ADDR_W)
   ) u_if_id (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_can_load && !w_is_halt),
      .i_kill  (w_kill),
      .i_ready (bus.id_ready),
      .i_pc    (r_pc),
      .i_instr (bus.imem_instr),
      .o_valid (bus.out_valid),
      .o_pc    (bus.out_pc),
      .o_instr (bus.out_instr)
   );

   assign bus.imem_pc = r_pc;
   assign halted      = (r_state == S_HALTED);
   assign fault       = (r_state == S_FAULT);
   assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: expected transfers are queued per scenario and
// popped by a monitor on every accepted IF/ID transfer.
module tb_fetch_unit;
   import fetch_pkg::*;

   typedef struct {
      logic [7:0]  pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        halted;
   logic        fault;
   logic [31:0] fetch_count;
   logic [31:0] mem [256];
   exp_t        sb [$];
   int          n_checks;
   int          n_errs;

   fetch_unit_if #(.ADDR_W(8)) bus ();

   fetch_unit #(.ADDR_W(8), .RESET_PC(8'd0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.master),
      .halted      (halted),
      .fault       (fault),
      .fetch_count (fetch_count)
   );

   assign bus.imem_instr = mem[bus.imem_pc];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int pc);
      exp_t e;
      e.pc    = pc[7:0];
      e.instr = mem[pc];
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = 32'd0;
      sb.delete();
      #3;
      check("rst_valid",   {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_pc",  {24'd0, bus.out_pc},    32'd0);
      check("rst_instr",   bus.out_instr,          NOP_WORD);
      check("rst_halted",  {31'd0, halted},        32'd0);
      check("rst_fault",   {31'd0, fault},         32'd0);
      check("rst_count",   fetch_count,            32'd0);
      check("rst_imem_pc", {24'd0, bus.imem_pc},   32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every accepted, non-wrong-path transfer must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.id_ready && !bus.redirect_valid) begin
         if (sb.size() == 0) begin
            check("sb_underflow", {24'd0, bus.out_pc}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("xfer_pc",    {24'd0, bus.out_pc}, {24'd0, e.pc});
            check("xfer_instr", bus.out_instr,       e.instr);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errs   = 0;
      rst_n    = 1'b1;
      bus.id_ready       = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = NOP_WORD;
      #2;

      // Run to halt
      mem[0] = 32'h3e80_0293;
      mem[1] = 32'h0051_2023;
      mem[2] = HALT_WORD;
      bus.id_ready = 1'b1;
      do_reset();
      push(0); push(1);
      check("t1_imem_pc0", {24'd0, bus.imem_pc}, 32'd0);
      tick();
      check("t1_vld_c1", {31'd0, bus.out_valid}, 32'd1);
      check("t1_pc_c1",  {24'd0, bus.out_pc},    32'd0);
      tick();
      check("t1_pc_c2",   {24'd0, bus.out_pc},  32'd1);
      check("t1_imem_c2", {24'd0, bus.imem_pc}, 32'd2);
      tick();
      check("t1_halted", {31'd0, halted},        32'd1);
      check("t1_vld_c3", {31'd0, bus.out_valid}, 32'd0);
      check("t1_count",  fetch_count,            32'd2);
      tick(); tick();
      check("t1_vld_after",  {31'd0, bus.out_valid}, 32'd0);
      check("t1_imem_after", {24'd0, bus.imem_pc},   32'd2);
      check("t1_sb_empty",   sb.size(),              32'd0);

      // Stall hold
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      mem[8] = HALT_WORD;
      bus.id_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) push(i);
      tick();
      check("t2_pc_c1", {24'd0, bus.out_pc}, 32'd0);
      bus.id_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t2_stall_pc",    {24'd0, bus.out_pc},    32'd0);
         check("t2_stall_instr", bus.out_instr,          32'h1000_0000);
         check("t2_stall_imem",  {24'd0, bus.imem_pc},   32'd1);
         check("t2_stall_vld",   {31'd0, bus.out_valid}, 32'd1);
      end
      bus.id_ready = 1'b1;
      repeat (10) tick();
      check("t2_halted",   {31'd0, halted}, 32'd1);
      check("t2_count",    fetch_count,     32'd8);
      check("t2_sb_empty", sb.size(),       32'd0);

      // Redirect with concurrent transfer, then redirect out of HALTED
      for (int i = 0; i < 256; i++) mem[i] = NOP_WORD;
      mem[0] = 32'hA000_0000;
      mem[1] = 32'hA000_0001;
      mem[6] = HALT_WORD;
      bus.id_ready = 1'b1;
      do_reset();
      push(2); push(3); push(4); push(5);
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h8;
      tick();
      bus.redirect_valid = 1'b0;
      check("t3_killed_vld", {31'd0, bus.out_valid}, 32'd0);
      check("t3_imem_tgt",   {24'd0, bus.imem_pc},   32'd2);
      check("t3_count_skip", fetch_count,            32'd0);
      tick();
      check("t3_tgt_vld", {31'd0, bus.out_valid}, 32'd1);
      check("t3_tgt_pc",  {24'd0, bus.out_pc},    32'd2);
      repeat (6) tick();
      check("t3_halted1", {31'd0, halted}, 32'd1);
      check("t3_count1",  fetch_count,     32'd4);
      push(4); push(5);
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h10;
      tick();
      bus.redirect_valid = 1'b0;
      check("t3_unhalt",    {31'd0, halted},        32'd0);
      check("t3_imem_4",    {24'd0, bus.imem_pc},   32'd4);
      check("t3_bubble",    {31'd0, bus.out_valid}, 32'd0);
      tick();
      check("t3_resume_pc", {24'd0, bus.out_pc},    32'd4);
      repeat (5) tick();
      check("t3_halted2",   {31'd0, halted}, 32'd1);
      check("t3_count2",    fetch_count,     32'd6);
      check("t3_sb_empty",  sb.size(),       32'd0);

      // Illegal redirects: misaligned and out of range
      for (int i = 0; i < 256; i++) mem[i] = NOP_WORD;
      for (int t = 0; t < 2; t++) begin
         logic [31:0] bad;
         bad = (t == 0) ? 32'h6 : 32'h400;
         bus.id_ready = 1'b0;
         do_reset();
         tick();
         bus.redirect_valid = 1'b1;
         bus.redirect_addr  = bad;
         tick();
         bus.redirect_valid = 1'b0;
         check("t4_fault", {31'd0, fault},         32'd1);
         check("t4_vld",   {31'd0, bus.out_valid}, 32'd0);
         check("t4_imem",  {24'd0, bus.imem_pc},   32'd1);
         bus.id_ready = 1'b1;
         tick();
         bus.redirect_valid = 1'b1;
         bus.redirect_addr  = 32'h10;
         tick();
         bus.redirect_valid = 1'b0;
         repeat (3) tick();
         check("t4_fault_sticky", {31'd0, fault},         32'd1);
         check("t4_imem_frozen",  {24'd0, bus.imem_pc},   32'd1);
         check("t4_vld_forced",   {31'd0, bus.out_valid}, 32'd0);
         check("t4_count",        fetch_count,            32'd0);
      end

      // PC wrap
      for (int i = 0; i < 256; i++) mem[i] = 32'h0100_0000 | i;
      mem[2] = HALT_WORD;
      bus.id_ready = 1'b1;
      do_reset();
      push(255); push(0); push(1);
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h3FC;
      tick();
      bus.redirect_valid = 1'b0;
      check("t5_imem_255", {24'd0, bus.imem_pc},   32'd255);
      check("t5_bubble",   {31'd0, bus.out_valid}, 32'd0);
      tick();
      check("t5_pc_255", {24'd0, bus.out_pc}, 32'd255);
      tick();
      check("t5_pc_0",   {24'd0, bus.out_pc}, 32'd0);
      repeat (4) tick();
      check("t5_halted",   {31'd0, halted}, 32'd1);
      check("t5_count",    fetch_count,     32'd3);
      check("t5_sb_empty", sb.size(),       32'd0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | i;
      mem[4] = HALT_WORD;
      bus.id_ready = 1'b1;
      do_reset();
      push(0); push(1); push(2);
      repeat (4) tick();
      check("t6_pre_pc",    {24'd0, bus.out_pc}, 32'd3);
      check("t6_pre_count", fetch_count,         32'd3);
      rst_n = 1'b0;
      #1;
      check("t6_async_vld",   {31'd0, bus.out_valid}, 32'd0);
      check("t6_async_count", fetch_count,            32'd0);
      check("t6_async_halt",  {31'd0, halted},        32'd0);
      check("t6_async_fault", {31'd0, fault},         32'd0);
      check("t6_async_imem",  {24'd0, bus.imem_pc},   32'd0);
      check("t6_sb_drained",  sb.size(),              32'd0);
      push(0); push(1); push(2); push(3);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check("t6_first_pc",  {24'd0, bus.out_pc},    32'd0);
      check("t6_first_vld", {31'd0, bus.out_valid}, 32'd1);
      repeat (6) tick();
      check("t6_halted",   {31'd0, halted}, 32'd1);
      check("t6_count",    fetch_count,     32'd4);
      check("t6_sb_empty", sb.size(),       32'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
